// File: rtl/lockpick_pkg.sv
// Shared types and constants for the lockpick round sequencer.
package lockpick_pkg;

    localparam int unsigned LFSR_W       = 16;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam int unsigned DEF_NUM_PINS = 4;
    localparam int unsigned DEF_PIN_W    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

    // One right-shift step of the Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/lockpick_lfsr.sv
// Free-running 16-bit Galois LFSR used as the secret source.
module lockpick_lfsr
    import lockpick_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Advance one step every cycle.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // State register, reloads the seed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/lockpick_round_ctrl.sv
// Round sequencer: arms a secret, scores guesses, counts tries, ends in OPEN or LOCKOUT.
// Optional near-miss hint counter is enabled by defining LOCKPICK_HINT_EN.
module lockpick_round_ctrl
    import lockpick_pkg::*;
#(
    parameter int unsigned NUM_PINS       = DEF_NUM_PINS,
    parameter int unsigned PIN_W          = DEF_PIN_W,
    parameter int unsigned MAX_TRIES      = 7,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              secret_sel_i,
    input  logic [NUM_PINS*PIN_W-1:0]         secret_i,
    input  logic                              guess_valid_i,
    input  logic [NUM_PINS*PIN_W-1:0]         guess_i,
    output logic                              guess_ready_o,
    output logic [NUM_PINS-1:0]               pins_set_o,
    output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left_o,
    output logic [$clog2(NUM_PINS+1)-1:0]     hint_o,
    output logic [2:0]                        state_o,
    output logic                              unlocked_o,
    output logic                              locked_out_o
);

    localparam int unsigned SEC_W  = NUM_PINS * PIN_W;
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned HINT_W = $clog2(NUM_PINS + 1);
    localparam int unsigned CNT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [LFSR_W-1:0] lfsr_w;
    logic              unused_lfsr;

    state_e              state_q, state_d;
    logic [SEC_W-1:0]    secret_q, secret_d;
    logic [SEC_W-1:0]    guess_q, guess_d;
    logic [NUM_PINS-1:0] pins_q, pins_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                unlocked_q, unlocked_d;
    logic                locked_q, locked_d;
    logic [NUM_PINS-1:0] match;

    lockpick_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_w)
    );

    // Only the low bits seed the secret; fold the rest so nothing dangles.
    assign unused_lfsr = ^lfsr_w;

    // Per-pin exact match of the latched guess against the secret.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            match[i] = (guess_q[i*PIN_W +: PIN_W] == secret_q[i*PIN_W +: PIN_W]);
        end
    end

`ifdef LOCKPICK_HINT_EN
    logic [HINT_W-1:0] hint_q, hint_d;
    logic [HINT_W-1:0] near_cnt;
    logic [PIN_W:0]    g_ext, s_ext;

    // Count pins whose digits differ by exactly one, without wrap-around.
    always_comb begin
        near_cnt = '0;
        g_ext    = '0;
        s_ext    = '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            g_ext = {1'b0, guess_q[i*PIN_W +: PIN_W]};
            s_ext = {1'b0, secret_q[i*PIN_W +: PIN_W]};
            if ((g_ext == s_ext + (PIN_W+1)'(1)) || (s_ext == g_ext + (PIN_W+1)'(1))) begin
                near_cnt = near_cnt + HINT_W'(1);
            end
        end
    end
`endif

    // Next-state, datapath updates and registered output decode.
    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        guess_d  = guess_q;
        pins_d   = pins_q;
        tries_d  = tries_q;
        cnt_d    = cnt_q;
`ifdef LOCKPICK_HINT_EN
        hint_d   = hint_q;
`endif
        case (state_q)
            IDLE, OPEN: begin
                if (start_i) begin
                    secret_d = secret_sel_i ? secret_i : lfsr_w[SEC_W-1:0];
                    tries_d  = TRY_W'(MAX_TRIES);
                    pins_d   = '0;
`ifdef LOCKPICK_HINT_EN
                    hint_d   = '0;
`endif
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (guess_valid_i && ready_q) begin
                    guess_d = guess_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                pins_d  = match;
                tries_d = tries_q - TRY_W'(1);
`ifdef LOCKPICK_HINT_EN
                hint_d  = near_cnt;
`endif
                if (&match) begin
                    state_d = OPEN;
                end else if (tries_q == TRY_W'(1)) begin
                    state_d = LOCKOUT;
                    cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
                end else begin
                    state_d = PLAY;
                end
            end
            LOCKOUT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        ready_d    = (state_d == PLAY);
        unlocked_d = (state_d == OPEN);
        locked_d   = (state_d == LOCKOUT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            secret_q   <= '0;
            guess_q    <= '0;
            pins_q     <= '0;
            tries_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
`ifdef LOCKPICK_HINT_EN
            hint_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            secret_q   <= secret_d;
            guess_q    <= guess_d;
            pins_q     <= pins_d;
            tries_q    <= tries_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            unlocked_q <= unlocked_d;
            locked_q   <= locked_d;
`ifdef LOCKPICK_HINT_EN
            hint_q     <= hint_d;
`endif
        end
    end

    assign guess_ready_o = ready_q;
    assign pins_set_o    = pins_q;
    assign tries_left_o  = tries_q;
    assign state_o       = state_q;
    assign unlocked_o    = unlocked_q;
    assign locked_out_o  = locked_q;
`ifdef LOCKPICK_HINT_EN
    assign hint_o        = hint_q;
`else
    assign hint_o        = '0;
`endif

endmodule

// File: tb/tb_lockpick_round_ctrl.sv
// Self-checking bench for lockpick_round_ctrl (MAX_TRIES=3, LOCKOUT_CYCLES=8).
module tb_lockpick_round_ctrl;

    localparam int MAXT = 3;
    localparam int LOCK = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        secret_sel_i = 1'b0;
    logic [11:0] secret_i = '0;
    logic        guess_valid_i = 1'b0;
    logic [11:0] guess_i = '0;
    logic        guess_ready_o;
    logic [3:0]  pins_set_o;
    logic [1:0]  tries_left_o;
    logic [2:0]  hint_o;
    logic [2:0]  state_o;
    logic        unlocked_o;
    logic        locked_out_o;

    int checks = 0;
    int errors = 0;

    // Reference state of the round, kept at game level.
    logic [15:0] lfsr_m;
    logic [11:0] sec_m;
    int          tries_m;
    int          exp_state;
    logic [3:0]  pins_m;
    int          hint_m;

    lockpick_round_ctrl #(
        .NUM_PINS(4), .PIN_W(3), .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCK), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .secret_sel_i(secret_sel_i),
        .secret_i(secret_i), .guess_valid_i(guess_valid_i), .guess_i(guess_i),
        .guess_ready_o(guess_ready_o), .pins_set_o(pins_set_o), .tries_left_o(tries_left_o),
        .hint_o(hint_o), .state_o(state_o), .unlocked_o(unlocked_o), .locked_out_o(locked_out_o)
    );

    always #5 clk = ~clk;

    // Model LFSR: Galois, mask 16'hB400, one right shift per clock.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int digit(input logic [11:0] v, input int i);
        return int'((v >> (3 * i)) & 12'd7);
    endfunction

    function automatic logic [3:0] score(input logic [11:0] g, input logic [11:0] s);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (digit(g, i) == digit(s, i));
        return m;
    endfunction

    function automatic int near(input logic [11:0] g, input logic [11:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (digit(g, i) - digit(s, i) == 1 || digit(s, i) - digit(g, i) == 1) n++;
        end
        return n;
    endfunction

    task automatic chk_all(input string ctx);
        chk({ctx, "_state"},  32'(state_o),       32'(exp_state));
        chk({ctx, "_tries"},  32'(tries_left_o),  32'(tries_m));
        chk({ctx, "_pins"},   32'(pins_set_o),    32'(pins_m));
        chk({ctx, "_hint"},   32'(hint_o),        32'(hint_m));
        chk({ctx, "_ready"},  32'(guess_ready_o), 32'(exp_state == 1));
        chk({ctx, "_open"},   32'(unlocked_o),    32'(exp_state == 3));
        chk({ctx, "_locked"}, 32'(locked_out_o),  32'(exp_state == 4));
    endtask

    // Start a round from IDLE/OPEN; optionally offer a guess in the same cycle.
    task automatic do_start(input bit sel, input logic [11:0] sec, input bit with_guess);
        start_i = 1'b1;
        secret_sel_i = sel;
        secret_i = sec;
        guess_valid_i = with_guess;
        guess_i = 12'o7777;
        sec_m = sel ? sec : lfsr_m[11:0];
        tick();
        start_i = 1'b0;
        guess_valid_i = 1'b0;
        exp_state = 1;
        tries_m = MAXT;
        pins_m = '0;
        hint_m = 0;
        chk_all("start");
    endtask

    // Offer one guess in PLAY; hold keeps valid high through the CHECK cycle.
    task automatic do_guess(input logic [11:0] g, input bit hold);
        guess_valid_i = 1'b1;
        guess_i = g;
        tick();
        chk("guess_in_check", 32'(state_o), 32'd2);
        chk("guess_ready_low", 32'(guess_ready_o), 32'd0);
        if (!hold) guess_valid_i = 1'b0;
        tick();
        guess_valid_i = 1'b0;
        pins_m = score(g, sec_m);
`ifdef LOCKPICK_HINT_EN
        hint_m = near(g, sec_m);
`else
        hint_m = 0;
`endif
        tries_m = tries_m - 1;
        if (pins_m == 4'hF)    exp_state = 3;
        else if (tries_m == 0) exp_state = 4;
        else                   exp_state = 1;
        chk_all("guess");
    endtask

    // Watch the lockout window, poking start during its first cycles.
    task automatic wait_lockout(input bit poke_start);
        int n = 0;
        while (locked_out_o === 1'b1 && n < 50) begin
            start_i = poke_start && (n < 3);
            n++;
            tick();
        end
        start_i = 1'b0;
        chk("lockout_len", 32'(n), 32'(LOCK));
        exp_state = 0;
        chk_all("after_lockout");
    endtask

    initial begin
        logic [11:0] g;
        logic [11:0] sv;
        bit          sel;

        exp_state = 0; tries_m = 0; pins_m = '0; hint_m = 0; sec_m = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst = 1'b0;
        tick();

        // Start with a simultaneous guess: start wins, guess dropped.
        do_start(1'b1, 12'o1234, 1'b1);
        tick();
        chk_all("guess_dropped_on_start");

        // Correct guess opens; OPEN holds and ignores guesses.
        do_guess(12'o1234, 1'b0);
        guess_valid_i = 1'b1;
        guess_i = 12'o0000;
        repeat (3) tick();
        guess_valid_i = 1'b0;
        chk_all("open_hold");

        // Partial match, valid held through CHECK counts once.
        do_start(1'b1, 12'o1234, 1'b0);
        do_guess(12'o1200, 1'b1);
        tick();
        chk_all("held_valid_once");

        // Near miss, then lockout with start ignored.
        do_guess(12'o1244, 1'b0);
        do_guess(12'o0000, 1'b0);
        wait_lockout(1'b1);

        // Win on the last try.
        do_start(1'b1, 12'o1234, 1'b0);
        do_guess(12'o0000, 1'b0);
        do_guess(12'o0000, 1'b0);
        do_guess(12'o1234, 1'b0);

        // No wrap in near-miss counting.
        do_start(1'b1, 12'o0234, 1'b0);
        do_guess(12'o7234, 1'b0);

        // Reset asserted mid-CHECK clears everything at once.
        guess_valid_i = 1'b1;
        guess_i = 12'o1111;
        tick();
        guess_valid_i = 1'b0;
        chk("pre_reset_check", 32'(state_o), 32'd2);
        rst = 1'b1;
        #1;
        exp_state = 0; tries_m = 0; pins_m = '0; hint_m = 0;
        chk_all("mid_check_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();

        // LFSR-drawn secret matches the model draw at the start edge.
        do_start(1'b0, 12'o0000, 1'b0);
        g = sec_m ^ 12'o0001;
        do_guess(g, 1'b0);
        do_guess(sec_m, 1'b0);

        // Randomized rounds against the game-level model.
        for (int r = 0; r < 30; r++) begin
            sel = 1'($urandom_range(0, 1));
            sv  = 12'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            do_start(sel, sv, 1'b0);
            while (exp_state == 1) begin
                repeat ($urandom_range(0, 2)) tick();
                g = sec_m;
                if ($urandom_range(0, 2) != 0) begin
                    for (int i = 0; i < 4; i++) begin
                        if ($urandom_range(0, 1) == 1) g[3*i +: 3] = 3'($urandom_range(0, 7));
                    end
                end
                do_guess(g, 1'($urandom_range(0, 1)));
                if (exp_state == 1 && guess_valid_i == 1'b0) begin
                    chk("rand_play_ready", 32'(guess_ready_o), 32'd1);
                end
            end
            if (exp_state == 4) wait_lockout(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
